uart_prog_loader: RTL

- Sits upstream of the instruction-fetch ROM. Turns the UART receiver's byte stream into 32-bit word writes on the ROM's programming port (upg_wen/upg_adr/upg_dat/upg_done).
- Frame format: 16-bit word count, then payload words, then a 1-byte XOR checksum.
- Holds the CPU off while a load is in progress.

---
 rtl/uart_prog_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART byte stream to program-ROM word writes with length, checksum and timeout.
module uart_prog_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              cpu_hold_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

  state_t          state, state_nx;
  logic [15:0]     len;
  logic [IW-1:0]   widx;
  logic [1:0]      bidx;
  logic [7:0]      csum;
  logic [23:0]     shreg;
  logic [TW-1:0]   tcnt;
  logic            busy;
  logic            timeout;
  logic            word_last;
  logic            len_bad;
  logic            len_zero;

  assign busy      = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
  assign timeout   = busy && !rx_valid && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign word_last = (32'(widx) + 32'd1) == 32'(len);
  assign len_bad   = 32'({rx_data, len[7:0]}) > MAX_LEN;
  assign len_zero  = ({rx_data, len[7:0]} == 16'd0);

  assign busy_o     = busy;
  assign cpu_hold_o = busy;
  assign upg_done_o = (state == DONE);
  assign err_o      = (state == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = LEN_LO;
      LEN_LO: begin
        if (rx_valid)     state_nx = LEN_HI;
        else if (timeout) state_nx = ERR;
      end
      LEN_HI: begin
        if (rx_valid)     state_nx = len_bad ? ERR : (len_zero ? CSUM : DATA);
        else if (timeout) state_nx = ERR;
      end
      DATA: begin
        if (rx_valid && bidx == 2'd3 && word_last) state_nx = CSUM;
        else if (timeout)                          state_nx = ERR;
      end
      CSUM: begin
        if (rx_valid)     state_nx = (rx_data == csum) ? DONE : ERR;
        else if (timeout) state_nx = ERR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The write is registered so it lands the cycle after the 4th byte while DATA keeps accepting bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len       <= '0;
      widx      <= '0;
      bidx      <= '0;
      csum      <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      upg_wen_o <= 1'b0;
      upg_adr_o <= '0;
      upg_dat_o <= '0;
    end else begin
      upg_wen_o <= 1'b0;
      if (!busy || rx_valid) tcnt <= '0;
      else                   tcnt <= tcnt + TW'(1);

      if (!busy && start) begin
        widx <= '0;
        bidx <= '0;
        csum <= '0;
      end

      if (rx_valid) begin
        case (state)
          LEN_LO: len[7:0]  <= rx_data;
          LEN_HI: len[15:8] <= rx_data;
          DATA: begin
            csum <= csum ^ rx_data;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_adr_o <= widx[ADDR_W-1:0];
              upg_dat_o <= {rx_data, shreg};
              widx      <= widx + IW'(1);
            end else begin
              shreg[{bidx, 3'b000} +: 8] <= rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
